// File: rtl/tlc_pkg.sv
// Shared constants and types for the TLC5955 serial bus arbiter.
package tlc_pkg;

  localparam int   TLC_BITS = 769;
  localparam logic SEL_CTRL = 1'b1;
  localparam logic SEL_GS   = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SLO,
    ST_SHI,
    ST_TAIL,
    ST_LATCH,
    ST_FIN
  } tlc_state_e;

  typedef enum logic {
    GRANT_CFG,
    GRANT_GS
  } grant_e;

endpackage

// File: rtl/tlc_bus_arbiter_shift_engine.sv
// Shift-and-latch sequencer for one TLC5955 transfer: N bits on SDO/SCLK, then a LAT pulse.
//
// state | meaning
// IDLE  | waiting for start
// PRE   | grant cycle, first bit being fetched by the requester
// SLO   | present next bit on SDO, SCLK low
// SHI   | SCLK high, device samples SDO
// TAIL  | return SCLK low after the last bit
// LATCH | LAT high
// FIN   | LAT low, done pulse
module tlc_shift_engine
  import tlc_pkg::*;
#(
  parameter int NUM_SHIFT = 8,
  parameter int CHAIN_LEN = 1,
  localparam int N_BITS = TLC_BITS * CHAIN_LEN,
  localparam int IDX_W  = $clog2(N_BITS)
) (
  input  logic                 spiClk,
  input  logic                 nReset,
  input  logic                 start,
  input  logic                 sel_ctrl,
  input  logic [NUM_SHIFT-1:0] data_bits,
  output logic                 sclk,
  output logic [NUM_SHIFT-1:0] sdo,
  output logic                 lat,
  output logic [IDX_W-1:0]     bit_idx,
  output logic                 done
);

  localparam int DEV_W = $clog2(TLC_BITS);

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_PRE   = ST_PRE;
  localparam logic [2:0] S_SLO   = ST_SLO;
  localparam logic [2:0] S_SHI   = ST_SHI;
  localparam logic [2:0] S_TAIL  = ST_TAIL;
  localparam logic [2:0] S_LATCH = ST_LATCH;
  localparam logic [2:0] S_FIN   = ST_FIN;

  logic [2:0]       state;
  logic [IDX_W-1:0] bits_left;
  // Bits until the next device select slot; zero means this bit is the select bit.
  logic [DEV_W-1:0] dev_left;
  logic             sel_q;

  always_ff @(posedge spiClk) begin
    if (!nReset) begin
      state     <= S_IDLE;
      sclk      <= 1'b0;
      lat       <= 1'b0;
      sdo       <= '0;
      bit_idx   <= '0;
      bits_left <= '0;
      dev_left  <= '0;
      sel_q     <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_PRE;
            bit_idx   <= '0;
            bits_left <= IDX_W'(N_BITS - 1);
            dev_left  <= '0;
            sel_q     <= sel_ctrl;
          end
        end
        S_PRE: state <= S_SLO;
        S_SLO: begin
          sdo      <= (dev_left == '0) ? {NUM_SHIFT{sel_q}} : data_bits;
          sclk     <= 1'b0;
          bit_idx  <= bit_idx + IDX_W'(1);
          dev_left <= (dev_left == '0) ? DEV_W'(TLC_BITS - 1) : dev_left - DEV_W'(1);
          state    <= S_SHI;
        end
        S_SHI: begin
          sclk <= 1'b1;
          if (bits_left == '0) begin
            state <= S_TAIL;
          end else begin
            bits_left <= bits_left - IDX_W'(1);
            state     <= S_SLO;
          end
        end
        S_TAIL: begin
          sclk  <= 1'b0;
          state <= S_LATCH;
        end
        S_LATCH: begin
          lat   <= 1'b1;
          state <= S_FIN;
        end
        S_FIN: begin
          lat   <= 1'b0;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/tlc_bus_arbiter.sv
// Round-robin arbiter for the shared TLC5955 bus between config and grayscale requesters.
// Grayscale is held off until one config transfer has completed since reset.
module tlc_bus_arbiter
  import tlc_pkg::*;
#(
  parameter int NUM_SHIFT = 8,
  parameter int CHAIN_LEN = 1,
  localparam int N_BITS = TLC_BITS * CHAIN_LEN,
  localparam int IDX_W  = $clog2(N_BITS)
) (
  input  logic                 spiClk,
  input  logic                 nReset,
  input  logic                 cfgReq,
  output logic                 cfgAck,
  output logic                 cfgDone,
  input  logic                 cfgBit,
  input  logic                 gsReq,
  output logic                 gsAck,
  output logic                 gsDone,
  input  logic [NUM_SHIFT-1:0] gsBits,
  output logic [IDX_W-1:0]     bitIdx,
  output logic                 grantCfg,
  output logic                 cfgValid,
  output logic                 busy,
  output logic                 SCLK,
  output logic                 LAT,
  output logic [NUM_SHIFT-1:0] SDO
);

  grant_e               last_grant;
  logic                 cfg_ok;
  logic                 gs_ok;
  logic                 pick_cfg;
  logic                 start;
  logic                 eng_done;
  logic [NUM_SHIFT-1:0] shift_bits;

  always_comb begin
    cfg_ok   = cfgReq;
    gs_ok    = gsReq && cfgValid;
    pick_cfg = cfg_ok && (!gs_ok || (last_grant == GRANT_GS));
    start    = !busy && (cfg_ok || gs_ok);
  end

  always_ff @(posedge spiClk) begin
    if (!nReset) begin
      busy       <= 1'b0;
      cfgAck     <= 1'b0;
      gsAck      <= 1'b0;
      cfgValid   <= 1'b0;
      last_grant <= GRANT_GS;
    end else begin
      cfgAck <= start && pick_cfg;
      gsAck  <= start && !pick_cfg;
      if (start) begin
        busy       <= 1'b1;
        last_grant <= pick_cfg ? GRANT_CFG : GRANT_GS;
      end else if (eng_done) begin
        busy <= 1'b0;
        if (last_grant == GRANT_CFG) cfgValid <= 1'b1;
      end
    end
  end

  assign grantCfg   = (last_grant == GRANT_CFG);
  assign cfgDone    = eng_done && grantCfg;
  assign gsDone     = eng_done && !grantCfg;
  // The grant register settles in the Ack cycle, before the first bit is fetched.
  assign shift_bits = grantCfg ? {NUM_SHIFT{cfgBit}} : gsBits;

  tlc_shift_engine #(
    .NUM_SHIFT(NUM_SHIFT),
    .CHAIN_LEN(CHAIN_LEN)
  ) u_engine (
    .spiClk   (spiClk),
    .nReset   (nReset),
    .start    (start),
    .sel_ctrl (pick_cfg ? SEL_CTRL : SEL_GS),
    .data_bits(shift_bits),
    .sclk     (SCLK),
    .sdo      (SDO),
    .lat      (LAT),
    .bit_idx  (bitIdx),
    .done     (eng_done)
  );

endmodule

// File: tb/tb_tlc_bus_arbiter.sv
// Directed self-checking bench for tlc_bus_arbiter (one chain-length-1 and one chain-length-2 instance).
module tb_tlc_bus_arbiter;

  logic spiClk = 1'b0;
  logic nReset;

  logic        cfgReq, cfgBit, gsReq;
  logic [7:0]  gsBits;
  logic        cfgAck, cfgDone, gsAck, gsDone, grantCfg, cfgValid, busy, SCLK, LAT;
  logic [9:0]  bitIdx;
  logic [7:0]  SDO;

  logic        cfgReq2, cfgBit2, gsReq2;
  logic [7:0]  gsBits2;
  logic        cfgAck2, cfgDone2, gsAck2, gsDone2, grantCfg2, cfgValid2, busy2, SCLK2, LAT2;
  logic [10:0] bitIdx2;
  logic [7:0]  SDO2;

  always #5 spiClk = ~spiClk;

  tlc_bus_arbiter #(.NUM_SHIFT(8), .CHAIN_LEN(1)) dut (
    .spiClk(spiClk), .nReset(nReset),
    .cfgReq(cfgReq), .cfgAck(cfgAck), .cfgDone(cfgDone), .cfgBit(cfgBit),
    .gsReq(gsReq), .gsAck(gsAck), .gsDone(gsDone), .gsBits(gsBits),
    .bitIdx(bitIdx), .grantCfg(grantCfg), .cfgValid(cfgValid), .busy(busy),
    .SCLK(SCLK), .LAT(LAT), .SDO(SDO)
  );

  tlc_bus_arbiter #(.NUM_SHIFT(8), .CHAIN_LEN(2)) dut2 (
    .spiClk(spiClk), .nReset(nReset),
    .cfgReq(cfgReq2), .cfgAck(cfgAck2), .cfgDone(cfgDone2), .cfgBit(cfgBit2),
    .gsReq(gsReq2), .gsAck(gsAck2), .gsDone(gsDone2), .gsBits(gsBits2),
    .bitIdx(bitIdx2), .grantCfg(grantCfg2), .cfgValid(cfgValid2), .busy(busy2),
    .SCLK(SCLK2), .LAT(LAT2), .SDO(SDO2)
  );

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Results of the most recent transfer on dut, cycles counted from the Ack cycle.
  int         ack_cyc, rises, bit_errs, first_err, rise_first, rise_last;
  int         lat_first, lat_cnt, done_cyc, done_cnt, done_wrong;
  logic       busy0, grant0, other_ack0, done_busy, after_busy;
  logic [9:0] idx0;
  logic [7:0] first_sdo;

  task automatic xfer(input bit use_cfg);
    logic       prev;
    logic [7:0] exp_b;
    ack_cyc = -1; rises = 0; bit_errs = 0; first_err = -1; rise_first = -1; rise_last = -1;
    lat_first = -1; lat_cnt = 0; done_cyc = -1; done_cnt = 0; done_wrong = 0;
    first_sdo = 8'hxx; after_busy = 1'bx; done_busy = 1'bx;
    if (use_cfg) cfgReq = 1'b1; else gsReq = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge spiClk);
      cfgBit = bitIdx[0];
      if (use_cfg ? cfgAck : gsAck) begin
        ack_cyc = i;
        break;
      end
    end
    cfgReq = 1'b0;
    gsReq  = 1'b0;
    if (ack_cyc < 0) return;
    busy0 = busy; idx0 = bitIdx; grant0 = grantCfg; other_ack0 = use_cfg ? gsAck : cfgAck;
    prev = SCLK;
    for (int c = 1; c <= 1546; c++) begin
      @(negedge spiClk);
      cfgBit = bitIdx[0];
      if (!prev && SCLK) begin
        if (rises == 0) exp_b = use_cfg ? 8'hFF : 8'h00;
        else            exp_b = use_cfg ? {8{rises[0]}} : 8'hA5;
        if (SDO !== exp_b) begin
          bit_errs++;
          if (first_err < 0) first_err = rises;
        end
        if (rises == 0) begin
          first_sdo  = SDO;
          rise_first = c;
        end
        rise_last = c;
        rises++;
      end
      prev = SCLK;
      if (LAT) begin
        lat_cnt++;
        if (lat_first < 0) lat_first = c;
      end
      if (c == done_cyc + 1) after_busy = busy;
      if (use_cfg ? cfgDone : gsDone) begin
        done_cyc  = c;
        done_cnt++;
        done_busy = busy;
      end
      if (use_cfg ? gsDone : cfgDone) done_wrong++;
    end
  endtask

  int         n_acks, ack_t[4];
  logic       ack_kind[4];
  int         cnt_a, cnt_b;
  logic [7:0] exp2;
  logic       prev2;

  initial begin
    nReset = 1'b0;
    cfgReq = 1'b0; cfgBit = 1'b0; gsReq = 1'b0; gsBits = 8'hA5;
    cfgReq2 = 1'b0; cfgBit2 = 1'b0; gsReq2 = 1'b0; gsBits2 = 8'hFF;

    // Reset values
    repeat (4) @(negedge spiClk);
    check("reset_outputs",
          {SCLK, LAT, SDO, bitIdx, busy, cfgAck, cfgDone, gsAck, gsDone, grantCfg, cfgValid},
          32'd0);
    nReset = 1'b1;

    // gs is held off until a config transfer has completed
    gsReq = 1'b1;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge spiClk);
      if (gsAck) cnt_a++;
      if (busy)  cnt_b++;
    end
    gsReq = 1'b0;
    check("gs_held_off_acks", cnt_a, 0);
    check("gs_held_off_busy", cnt_b, 0);
    check("cfgvalid_before_cfg", cfgValid, 1'b0);

    // Config transfer, cfgBit follows bitIdx[0]
    xfer(1'b1);
    check("cfg_ack_latency", ack_cyc, 0);
    check("cfg_cycle0_busy_idx_grant", {busy0, idx0, grant0, other_ack0}, {1'b1, 10'd0, 1'b1, 1'b0});
    check("cfg_first_sdo", first_sdo, 8'hFF);
    check("cfg_rise_count", rises, 769);
    check("cfg_bit_errors", bit_errs, 0);
    check("cfg_first_bad_bit", first_err, -1);
    check("cfg_rise_cycles", {rise_first[15:0], rise_last[15:0]}, {16'd3, 16'd1539});
    check("cfg_lat_cycle", lat_first, 1541);
    check("cfg_lat_width", lat_cnt, 1);
    check("cfg_done_cycle", done_cyc, 1542);
    check("cfg_done_count", {done_cnt[15:0], done_wrong[15:0]}, {16'd1, 16'd0});
    check("cfg_busy_at_done_then_idle", {done_busy, after_busy}, 2'b10);
    check("cfgvalid_after_cfg", cfgValid, 1'b1);

    // Grayscale transfer with 8'hA5 on the chains
    xfer(1'b0);
    check("gs_ack_latency", ack_cyc, 0);
    check("gs_cycle0_busy_idx_grant", {busy0, idx0, grant0, other_ack0}, {1'b1, 10'd0, 1'b0, 1'b0});
    check("gs_first_sdo", first_sdo, 8'h00);
    check("gs_rise_count", rises, 769);
    check("gs_bit_errors", bit_errs, 0);
    check("gs_lat_cycle", lat_first, 1541);
    check("gs_done_cycle", done_cyc, 1542);
    check("gs_done_count", {done_cnt[15:0], done_wrong[15:0]}, {16'd1, 16'd0});

    // Both requesting: grants alternate, cfg first since gs was granted last
    cfgReq = 1'b1; gsReq = 1'b1;
    n_acks = 0;
    for (int i = 0; i < 4 * 1544 + 40 && n_acks < 4; i++) begin
      @(negedge spiClk);
      if (cfgAck || gsAck) begin
        ack_kind[n_acks] = cfgAck;
        ack_t[n_acks]    = i;
        n_acks++;
      end
    end
    cfgReq = 1'b0; gsReq = 1'b0;
    check("rr_ack_count", n_acks, 4);
    if (n_acks == 4) begin
      check("rr_grant_order", {ack_kind[0], ack_kind[1], ack_kind[2], ack_kind[3]}, 4'b1010);
      check("rr_spacing_1", ack_t[1] - ack_t[0], 1544);
      check("rr_spacing_2", ack_t[2] - ack_t[1], 1544);
      check("rr_spacing_3", ack_t[3] - ack_t[2], 1544);
    end
    repeat (1600) @(negedge spiClk);
    check("rr_idle_after", busy, 1'b0);

    // Two devices per chain: select bit at 0 and 769
    cfgReq2 = 1'b1;
    cnt_a = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge spiClk);
      if (cfgAck2) begin
        cnt_a = i;
        break;
      end
    end
    cfgReq2 = 1'b0;
    check("chain2_ack_latency", cnt_a, 0);
    rises = 0; bit_errs = 0; done_cyc = -1; lat_first = -1;
    prev2 = SCLK2;
    for (int c = 1; c <= 3090; c++) begin
      @(negedge spiClk);
      if (!prev2 && SCLK2) begin
        exp2 = (rises == 0 || rises == 769) ? 8'hFF : 8'h00;
        if (SDO2 !== exp2) bit_errs++;
        rises++;
      end
      prev2 = SCLK2;
      if (LAT2 && lat_first < 0) lat_first = c;
      if (cfgDone2) done_cyc = c;
    end
    check("chain2_rise_count", rises, 1538);
    check("chain2_select_bits", bit_errs, 0);
    check("chain2_lat_cycle", lat_first, 3079);
    check("chain2_done_cycle", done_cyc, 3080);

    // Reset in cycle 700 of a config transfer
    cfgReq = 1'b1;
    cnt_a = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge spiClk);
      if (cfgAck) begin
        cnt_a = i;
        break;
      end
    end
    cfgReq = 1'b0;
    check("rst_ack_latency", cnt_a, 0);
    cnt_b = 0;
    for (int c = 1; c <= 700; c++) begin
      @(negedge spiClk);
      if (LAT) cnt_b++;
    end
    check("rst_busy_before", busy, 1'b1);
    nReset = 1'b0;
    @(negedge spiClk);
    check("rst_outputs_next_cycle",
          {SCLK, LAT, SDO, bitIdx, busy, cfgAck, cfgDone, gsAck, gsDone, grantCfg},
          32'd0);
    check("rst_cfgvalid_cleared", cfgValid, 1'b0);
    @(negedge spiClk);
    nReset = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge spiClk);
      if (LAT || busy) cnt_b++;
    end
    check("rst_no_latch_no_resume", cnt_b, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/tlc_bus_arbiter.md
# tlc_bus_arbiter

Arbitrates the shared TLC5955 serial bus (SCLK/SDO/LAT) in the spiClk domain between two requesters: control-register configuration and grayscale row data. It serialises one full 769-bit-per-device shift-and-latch transfer per grant and injects each device's select bit itself. It sits between the LED init/config logic, the row-buffer grayscale path and the board pins, and replaces the static init/run output mux.

## Interface
- NUM_SHIFT, 8: parallel SDO chains.
- CHAIN_LEN, 1: TLC5955 devices per chain; N = 769*CHAIN_LEN bits per transfer.
- spiClk  in  1  clock; SCLK = spiClk/2 during shift.
- nReset  in  1  reset, synchronous, active-low.
- cfgReq  in  1  level request for one config transfer.
- cfgAck  out  1  one-cycle pulse: cfg transfer granted.
- cfgDone  out  1  one-cycle pulse: cfg transfer latched.
- cfgBit  in  1  config bit for bitIdx, replicated to all chains.
- gsReq  in  1  level request for one grayscale transfer.
- gsAck  out  1  one-cycle pulse: gs transfer granted.
- gsDone  out  1  one-cycle pulse: gs transfer latched.
- gsBits  in  NUM_SHIFT  grayscale bit for bitIdx, one per chain.
- bitIdx  out  $clog2(N)  bit index requested; 0 = first bit shifted.
- grantCfg  out  1  1 while the current/last grant is cfg.
- cfgValid  out  1  set after first completed cfg transfer since reset.
- busy  out  1  transfer in progress.
- SCLK, LAT  out  1  TLC5955 shift clock / latch.
- SDO  out  NUM_SHIFT  serial data per chain.

## Operation
- States: IDLE, PRE, SLO, SHI, TAIL, LATCH, FIN.
- IDLE: on a grantable request, pulse the matching Ack, set grantCfg, bitIdx=0, go PRE.
- Grantable: cfgReq always; gsReq only when cfgValid=1. Until then gs is held off indefinitely.
- Both grantable in IDLE: round-robin, granting the requester not granted last. After reset, last = gs, so cfg wins first.
- Requests are level. A requester drops req on Ack or on Done. A req still high in the cycle after Done is a new request.
- Select bit: when bitIdx mod 769 == 0, the block drives 1 for cfg and 0 for gs and ignores the requester input. All other positions take cfgBit (replicated) or gsBits.
- SLO: SDO <= bit(bitIdx), SCLK <= 0, bitIdx <= bitIdx+1. SHI: SCLK <= 1. Repeat for N bits. After the last SHI go to TAIL.
- TAIL: SCLK <= 0. LATCH: LAT <= 1. FIN: LAT <= 0, pulse Done, set cfgValid if cfg, go IDLE.
- A req that drops mid-transfer has no effect; the transfer always completes.
- Reset mid-transfer: at the reset edge all outputs return to reset values and state returns to IDLE. No partial latch is issued (LAT stays 0). Requesters re-request.
- Reset values: SCLK=0, LAT=0, SDO=0, bitIdx=0, busy=0, all Ack/Done=0, grantCfg=0, cfgValid=0.

## Timing
- All outputs are registered. Cycle 0 is the cycle Ack is high (PRE), with busy=1 and bitIdx=0.
- Bit k (k=0..N-1): SDO=bit k with SCLK=0 in cycle 2+2k; SCLK=1 in cycle 3+2k. SDO is stable across the rising edge.
- bitIdx=k from cycle 2k. Data is sampled at the end of cycle 1+2k. Requesters therefore have 2 cycles and may register one stage.
- SCLK=0 in cycle 2N+2; LAT=1 in cycle 2N+3; LAT=0 with Done=1 and busy=1 in cycle 2N+4.
- busy=0 from cycle 2N+5. The earliest next Ack is cycle 2N+6.
- N=769: Done occurs in cycle 1542; a transfer occupies 1543 cycles.

## Structure
- Package tlc_pkg: TLC_BITS=769, SEL_CTRL=1'b1, SEL_GS=1'b0, state enum, grant enum {GRANT_CFG, GRANT_GS}.
- Sub-module tlc_shift_engine: the PRE..FIN sequencer (start, selCtrl, bit inputs → SCLK, SDO, LAT, bitIdx, done).
- The top level holds the arbiter, the round-robin/last-grant flag, cfgValid and the Ack/Done routing.

## Test plan
- Reset, then gsReq=1 only → no gsAck for 5000 cycles; busy=0; cfgValid=0.
- cfgReq=1 with cfgBit=bitIdx[0] → cfgAck in cycle 0; the first SDO bit is 1 on all chains; the 769 SCLK rising edges carry the expected bits; LAT high in cycle 1541; cfgDone in cycle 1542; cfgValid=1.
- cfgValid=1, then gsReq with gsBits=8'hA5 → first bit 0, the remaining 768 bits 8'hA5 on the chains, gsDone in cycle 1542.
- cfgReq and gsReq held high together → grants alternate cfg, gs, cfg, gs, and Acks are spaced 1544 cycles apart.
- CHAIN_LEN=2 → N=1538; select bit forced at bitIdx 0 and 769; Done in cycle 3080.
- nReset asserted in cycle 700 of a transfer → next cycle all outputs are at reset values, LAT is never 1, and cfgValid=0.
